// File: rtl/sram_req_initiator_pkg.sv
// rtl/sram_req_initiator_pkg.sv - shared types and width helpers for sram_req_initiator
package sram_req_initiator_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned calc_be_width(input int unsigned data_width,
                                                input int unsigned byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - response FIFO with registered head; push and pop may coincide
module sram_rsp_fifo #(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [Width-1:0] pop_data_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
  logic [CntWidth-1:0] count_q;
  logic [Width-1:0]    head_q;
  logic                do_pop;

  assign do_pop     = pop_i & (count_q != '0);
  assign wr_ptr_nxt = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
  assign rd_ptr_nxt = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
  assign empty_o    = (count_q == '0);
  assign pop_data_o = head_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // head_q always mirrors mem_q[rd_ptr_q]; a push into an empty (or draining-to-empty) FIFO bypasses mem
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_nxt;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      count_q <= count_q + CntWidth'(push_i) - CntWidth'(do_pop);
      if (push_i && ((count_q == '0) || (do_pop && (count_q == CntWidth'(1))))) begin
        head_q <= push_data_i;
      end else if (do_pop && (count_q > CntWidth'(1))) begin
        head_q <= mem_q[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/sram_req_initiator.sv
// rtl/sram_req_initiator.sv - request/response driver for a single-port SRAM
// Optional zero-init sweep after reset when SRAM_INIT_EN is defined.
module sram_req_initiator
  import sram_req_initiator_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = Latency + 2,
  localparam int unsigned AddrWidth = calc_addr_width(NumWords),
  localparam int unsigned BeWidth   = calc_be_width(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 init_done_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned RsvWidth = $clog2(RspDepth + 1);
  localparam logic [RsvWidth-1:0] RsvMax = RsvWidth'(RspDepth);

  if (Latency < 1) begin : g_latency_check
    $error("sram_req_initiator: Latency must be >= 1");
  end

  logic                 init_done;
  logic                 init_active;
  logic [AddrWidth-1:0] init_addr;
  logic [RsvWidth-1:0]  reserved_q;
  logic [Latency-1:0]   rd_pipe_q;
  logic                 req_fire, rd_fire, rsp_pop, fifo_empty;

`ifdef SRAM_INIT_EN
  init_state_e          state_q, state_d;
  logic [AddrWidth-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Address stops at the last word; the state change is what ends the sweep
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done   = 1'b0;
    init_active = 1'b0;
    case (state_q)
      INIT: begin
        init_active = 1'b1;
        if (init_addr_q == AddrWidth'(NumWords - 1)) begin
          state_d = RUN;
        end else begin
          init_addr_d = init_addr_q + AddrWidth'(1);
        end
      end
      RUN: init_done = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign init_addr = init_addr_q;
`else
  logic init_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign init_done   = init_done_q;
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  assign init_done_o = init_done;
  assign req_ready_o = init_done & (reserved_q < RsvMax);
  assign req_fire    = req_valid_i & req_ready_o;
  assign rd_fire     = req_fire & ~req_we_i;
  assign rsp_valid_o = ~fifo_empty;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (init_active) begin
      sram_req_o  = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = init_addr;
      sram_be_o   = '1;
    end else if (req_fire) begin
      sram_req_o   = 1'b1;
      sram_we_o    = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
      sram_be_o    = req_be_i;
    end
  end

  // Credits cover both in-flight reads and FIFO occupancy, so a push always finds room
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reserved_q <= '0;
      rd_pipe_q  <= '0;
    end else begin
      if (rd_fire && !rsp_pop) begin
        reserved_q <= reserved_q + RsvWidth'(1);
      end else if (!rd_fire && rsp_pop) begin
        reserved_q <= reserved_q - RsvWidth'(1);
      end
      rd_pipe_q[0] <= rd_fire;
      for (int i = 1; i < Latency; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  sram_rsp_fifo #(
    .Depth(RspDepth),
    .Width(DataWidth)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (rd_pipe_q[Latency-1]),
    .push_data_i(sram_rdata_i),
    .pop_i      (rsp_pop),
    .empty_o    (fifo_empty),
    .pop_data_o (rsp_rdata_o)
  );

endmodule

// File: tb/tb_sram_req_initiator.sv
// tb/tb_sram_req_initiator.sv - randomized bench with queue-based reference model
module tb_sram_req_initiator;

  localparam int NW = 16, DW = 32, BYW = 8, LAT = 3, RSP_DEPTH = LAT + 2, AW = 4, BEW = 4;
`ifdef SRAM_INIT_EN
  localparam int INIT_CYC = NW;
`else
  localparam int INIT_CYC = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done;
  logic sram_req, sram_we;
  logic [AW-1:0] req_addr, sram_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
  logic [BEW-1:0] req_be, sram_be;

  always #5 clk = ~clk;

  sram_req_initiator #(
    .NumWords(NW), .DataWidth(DW), .ByteWidth(BYW), .Latency(LAT), .RspDepth(RSP_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .init_done_o(init_done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Attached SRAM macro with fixed read latency
  logic [DW-1:0] smem [NW];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      for (int b = 0; b < BEW; b++) begin
        if (sram_be[b]) smem[sram_addr][b*BYW +: BYW] <= sram_wdata[b*BYW +: BYW];
      end
    end
    pipe[0] <= (sram_req && !sram_we) ? smem[sram_addr] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sram_rdata = pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] last_pop;
  int            cyc, outstanding, n_cmp, n_bad;
  bit            acc, dut_fire;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after the falling edge with inputs applied; checks this cycle and advances the model
  task automatic tick();
    bit exp_done, exp_ready, exp_valid, sweeping;
    logic [41:0] exp_bundle;
    #1;
    acc = 1'b0;
    dut_fire = req_valid && req_ready;
    if (!rst_n) begin
      expect_eq("rst_req_ready", req_ready, 0);
      expect_eq("rst_rsp_valid", rsp_valid, 0);
      expect_eq("rst_rsp_rdata", rsp_rdata, 0);
      expect_eq("rst_init_done", init_done, 0);
      expect_eq("rst_sram_port", {sram_req, sram_we, sram_addr, sram_wdata, sram_be}, 0);
    end else begin
      exp_done  = cyc >= INIT_CYC;
      exp_ready = exp_done && (outstanding < RSP_DEPTH);
      expect_eq("init_done", init_done, exp_done);
      expect_eq("req_ready", req_ready, exp_ready);
      acc = req_valid && exp_ready;
      sweeping = 1'b0;
      exp_bundle = '0;
`ifdef SRAM_INIT_EN
      if (cyc < NW) begin
        sweeping = 1'b1;
        exp_bundle = {1'b1, 1'b1, AW'(cyc), {DW{1'b0}}, {BEW{1'b1}}};
        ref_mem[cyc] = '0;
      end
`endif
      if (!sweeping && acc) exp_bundle = {1'b1, req_we, req_addr, req_wdata, req_be};
      expect_eq("sram_port", {sram_req, sram_we, sram_addr, sram_wdata, sram_be}, exp_bundle);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      expect_eq("rsp_valid", rsp_valid, exp_valid);
      if (rsp_valid && rsp_ready) last_pop = rsp_rdata;
      if (exp_valid) begin
        expect_eq("rsp_rdata", rsp_rdata, exp_q[0].data);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
      end
      if (acc) begin
        if (req_we) begin
          for (int b = 0; b < BEW; b++)
            if (req_be[b]) ref_mem[req_addr][b*BYW +: BYW] = req_wdata[b*BYW +: BYW];
        end else begin
          exp_q.push_back('{data: ref_mem[req_addr], avail: cyc + LAT + 1});
          outstanding++;
        end
      end
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input bit v, input bit we, input int addr, input logic [DW-1:0] wd,
                         input logic [BEW-1:0] be);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = wd;
    req_be    = be;
  endtask

  task automatic rand_req();
    set_req($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, NW - 1),
            $urandom, BEW'($urandom));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      rand_req();
      tick();
    end
    rst_n = 1'b1;
    cyc = 0;
    outstanding = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    set_req(0, 0, 0, '0, '0);
    rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    expect_eq("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int n, fires;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    outstanding = 0;
    last_pop = '0;
    for (int i = 0; i < NW; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    set_req(0, 0, 0, '0, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    do_reset(3);

    // First request held from cycle 0; acceptance cycle depends on init sweep
    set_req(1, 1, 5, 32'hDEADBEEF, '1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < NW + 10);
    expect_eq("first_accept_cycle", cyc - 1, INIT_CYC);
    set_req(1, 0, 5, '0, '0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 10);
    drain();
    expect_eq("deadbeef_readback", last_pop, 32'hDEADBEEF);

    // Back-to-back reads with consumer always ready
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1, 0, $urandom_range(0, NW - 1), '0, '0);
      tick();
      fires += int'(dut_fire);
    end
    expect_eq("b2b_issues", fires, 10);
    drain();

    // Back-pressure: credits cap accepted reads
    rsp_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 12; i++) begin
      set_req(1, 0, $urandom_range(0, NW - 1), '0, '0);
      tick();
      fires += int'(dut_fire);
    end
    expect_eq("credit_limit", fires, RSP_DEPTH);
    rsp_ready = 1'b1;
    tick();
    fires = int'(dut_fire);
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      fires += int'(dut_fire);
    end
    expect_eq("one_pop_one_credit", fires, 1);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_req();
      rsp_ready = $urandom_range(0, 9) < 6;
      tick();
    end
    drain();

    // Reset with two reads in flight
    set_req(1, 0, 2, '0, '0);
    tick();
    set_req(1, 0, 7, '0, '0);
    tick();
    set_req(0, 0, 0, '0, '0);
    tick();
    expect_eq("inflight_before_reset", outstanding, 2);
    do_reset(2);
    set_req(0, 0, 0, '0, '0);
    rsp_ready = 1'b1;
    repeat (NW + 14) tick();
    expect_eq("post_reset_rsp_valid", rsp_valid, 0);
    rsp_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      set_req(1, 0, $urandom_range(0, NW - 1), '0, '0);
      tick();
      fires += int'(dut_fire);
    end
    expect_eq("post_reset_credits", fires, RSP_DEPTH);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
